muldiv_sequencer: RTL and testbench

- Multi-cycle MULT/MULTU/DIV/DIVU engine for the MIPS EX stage, producing HI/LO.
- Owns no adder: every arithmetic step runs on the existing shared 32-bit ALU through the alu_* ports, one ALU operation per cycle.
- The parent connects the alu_* ports to the ALU instance and muxes ownership using busy.

---
 rtl/muldiv_sequencer_pkg.sv | 27 ++
 rtl/muldiv_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the multi-cycle multiply/divide sequencer: operation codes,
// ALU operation codes and small decode helpers.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_e;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUBU = 4'd2,
    ALU_NOR  = 4'd3
  } alu_code_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer producing HI/LO; every arithmetic step is one
// operation on the shared ALU reached through the alu_* ports.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int BitWidth = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  muldiv_op_e          op,
  input  logic [BitWidth-1:0] rs,
  input  logic [BitWidth-1:0] rt,
  input  logic                cancel,
  output logic                busy,
  output logic                done,
  output logic [BitWidth-1:0] hi,
  output logic [BitWidth-1:0] lo,
  output logic                div_zero,
  output logic [BitWidth-1:0] alu_a,
  output logic [BitWidth-1:0] alu_b,
  output alu_code_e           alu_control,
  input  logic [BitWidth-1:0] alu_c,
  input  logic                alu_carry,
  output logic [2:0]          dbg_state
);

  localparam int CntW = $clog2(BitWidth);
  localparam logic [CntW-1:0] LastIter = CntW'(BitWidth - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ABS_A  = 3'd1;
  localparam logic [2:0] S_ABS_B  = 3'd2;
  localparam logic [2:0] S_ITER   = 3'd3;
  localparam logic [2:0] S_FIX_LO = 3'd4;
  localparam logic [2:0] S_FIX_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]          state, state_nxt;
  logic [BitWidth-1:0] ph, ph_nxt, pl, pl_nxt, ma, ma_nxt, mb, mb_nxt;
  logic [CntW-1:0]     cnt, cnt_nxt;
  logic                neg_p, neg_p_nxt, neg_r, neg_r_nxt;
  logic                lo_zero, lo_zero_nxt;
  logic                is_div, is_div_nxt, is_signed, is_signed_nxt;
  logic                dz_nxt, quo_bit, fix_neg;
  logic [BitWidth-1:0] rem_shift;

  // Handshake: start is a request taken only when busy=0 (IDLE or DONE) and
  // cancel is low; busy acts as the not-ready signal, cancel overrides all.
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_comb begin
    state_nxt     = state;
    ph_nxt        = ph;
    pl_nxt        = pl;
    ma_nxt        = ma;
    mb_nxt        = mb;
    cnt_nxt       = cnt;
    neg_p_nxt     = neg_p;
    neg_r_nxt     = neg_r;
    lo_zero_nxt   = lo_zero;
    is_div_nxt    = is_div;
    is_signed_nxt = is_signed;
    dz_nxt        = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_control   = ALU_NONE;
    rem_shift     = {ph[BitWidth-2:0], pl[BitWidth-1]};
    quo_bit       = ph[BitWidth-1] | ~alu_carry;
    fix_neg       = is_div ? neg_r : neg_p;

    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (start) begin
          is_div_nxt    = op_is_div(op);
          is_signed_nxt = op_is_signed(op);
          neg_p_nxt     = rs[BitWidth-1] ^ rt[BitWidth-1];
          neg_r_nxt     = rs[BitWidth-1];
          cnt_nxt       = '0;
          ph_nxt        = '0;
          ma_nxt        = rs;
          mb_nxt        = rt;
          if (op_is_div(op) && (rt == '0)) begin
            state_nxt = S_DONE;
            ph_nxt    = rs;
            pl_nxt    = '1;
            dz_nxt    = 1'b1;
          end else if (op_is_signed(op)) begin
            state_nxt = S_ABS_A;
          end else begin
            state_nxt = S_ITER;
            pl_nxt    = op_is_div(op) ? rs : rt;
          end
        end
      end
      S_ABS_A: begin
        alu_a       = ma[BitWidth-1] ? '0 : ma;
        alu_b       = ma[BitWidth-1] ? ma : '0;
        alu_control = ma[BitWidth-1] ? ALU_SUBU : ALU_ADDU;
        ma_nxt      = alu_c;
        state_nxt   = S_ABS_B;
      end
      S_ABS_B: begin
        alu_a       = mb[BitWidth-1] ? '0 : mb;
        alu_b       = mb[BitWidth-1] ? mb : '0;
        alu_control = mb[BitWidth-1] ? ALU_SUBU : ALU_ADDU;
        mb_nxt      = alu_c;
        ph_nxt      = '0;
        pl_nxt      = is_div ? ma : alu_c;
        state_nxt   = S_ITER;
      end
      S_ITER: begin
        if (is_div) begin
          // Restoring division: subtract succeeds unless the shifted remainder
          // is below the divisor (carry) and no bit was shifted out of ph.
          alu_a       = rem_shift;
          alu_b       = mb;
          alu_control = ALU_SUBU;
          ph_nxt      = quo_bit ? alu_c : rem_shift;
          pl_nxt      = {pl[BitWidth-2:0], quo_bit};
        end else begin
          alu_a       = ph;
          alu_b       = pl[0] ? ma : '0;
          alu_control = ALU_ADDU;
          ph_nxt      = {alu_carry, alu_c[BitWidth-1:1]};
          pl_nxt      = {alu_c[0], pl[BitWidth-1:1]};
        end
        cnt_nxt = cnt + CntW'(1);
        if (cnt == LastIter) state_nxt = is_signed ? S_FIX_LO : S_DONE;
      end
      S_FIX_LO: begin
        alu_a       = neg_p ? '0 : pl;
        alu_b       = neg_p ? pl : '0;
        alu_control = neg_p ? ALU_SUBU : ALU_ADDU;
        pl_nxt      = alu_c;
        lo_zero_nxt = ~alu_carry;
        state_nxt   = S_FIX_HI;
      end
      S_FIX_HI: begin
        // A non-zero low word absorbs the +1 of the 64-bit negate, so the
        // high word is only inverted in that case.
        if (!fix_neg) begin
          alu_a       = ph;
          alu_control = ALU_ADDU;
        end else if (!is_div && !lo_zero) begin
          alu_a       = ph;
          alu_b       = ph;
          alu_control = ALU_NOR;
        end else begin
          alu_b       = ph;
          alu_control = ALU_SUBU;
        end
        ph_nxt    = alu_c;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (cancel) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ph        <= '0;
      pl        <= '0;
      ma        <= '0;
      mb        <= '0;
      cnt       <= '0;
      neg_p     <= 1'b0;
      neg_r     <= 1'b0;
      lo_zero   <= 1'b0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ph        <= ph_nxt;
      pl        <= pl_nxt;
      ma        <= ma_nxt;
      mb        <= mb_nxt;
      cnt       <= cnt_nxt;
      neg_p     <= neg_p_nxt;
      neg_r     <= neg_r_nxt;
      lo_zero   <= lo_zero_nxt;
      is_div    <= is_div_nxt;
      is_signed <= is_signed_nxt;
      if (state_nxt == S_DONE) begin
        hi       <= ph_nxt;
        lo       <= pl_nxt;
        div_zero <= dz_nxt;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: models the shared ALU, runs directed vectors,
// multi-cycle corner sequences and random operations against a 64-bit model.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  muldiv_op_e  op;
  logic [31:0] rs, rt;
  logic        cancel;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [31:0] alu_a, alu_b, alu_c;
  alu_code_e   alu_control;
  logic        alu_carry;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  muldiv_sequencer #(.BitWidth(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_zero(div_zero), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_c(alu_c), .alu_carry(alu_carry),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU as the parent EX stage would provide it
  always_comb begin
    alu_c     = '0;
    alu_carry = 1'b0;
    case (alu_control)
      ALU_ADDU: {alu_carry, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUBU: begin
        alu_c     = alu_a - alu_b;
        alu_carry = (alu_a < alu_b);
      end
      ALU_NOR:  alu_c = ~(alu_a | alu_b);
      default:  ;
    endcase
  end

  typedef struct {
    muldiv_op_e  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op
  function automatic logic [64:0] model(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p, q64, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      MULT: begin
        p = 64'(sa * sb);
        return {1'b0, p};
      end
      MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        return {1'b0, p};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          q64 = 64'(sq);
          r64 = 64'(sr);
          return {1'b0, r64[31:0], q64[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic int model_lat(input muldiv_op_e o, input logic [31:0] b);
    if (((o == DIV) || (o == DIVU)) && (b == 32'd0)) return 1;
    if ((o == MULT) || (o == DIV)) return 37;
    return 33;
  endfunction

  // Driver: called at a negedge; returns at the negedge of the done cycle.
  // inj > 0 pulses a competing start during that cycle of the operation.
  task automatic do_op(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b,
                       input int inj, output logic [31:0] h, output logic [31:0] l,
                       output logic z, output int lat);
    op = o; rs = a; rt = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == inj) begin
        start = 1'b1; op = DIVU; rs = 32'h1; rt = 32'h0;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    h = hi; l = lo; z = div_zero;
  endtask

  initial begin
    logic [31:0] h, l;
    logic        z;
    int          lat;
    logic [64:0] exp_v;
    muldiv_op_e  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
    vecs[1]  = '{MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 37};
    vecs[2]  = '{MULT,  32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 37};
    vecs[3]  = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 37};
    vecs[4]  = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
    vecs[5]  = '{DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[6]  = '{MULTU, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0, 33};
    vecs[7]  = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 37};
    vecs[8]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 37};
    vecs[9]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 37};
    vecs[10] = '{DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[11] = '{MULT,  32'd0,         32'hFFFF_FFFF, 32'd0,         32'd0,         1'b0, 37};

    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = MULT; rs = '0; rt = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    check("reset alu_a", 64'(alu_a), 64'd0);
    check("reset alu_b", 64'(alu_b), 64'd0);
    check("reset alu_control", 64'(alu_control), 64'(ALU_NONE));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, 0, h, l, z, lat);
      check($sformatf("vec%0d hi", i), 64'(h), 64'(vecs[i].hi));
      check($sformatf("vec%0d lo", i), 64'(l), 64'(vecs[i].lo));
      check($sformatf("vec%0d div_zero", i), 64'(z), 64'(vecs[i].dz));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d done pulse", i), 64'(done), 64'd0);
    end

    // Start while busy is ignored
    do_op(MULTU, 32'd3, 32'd5, 5, h, l, z, lat);
    check("busy start lo", 64'(l), 64'd15);
    check("busy start hi", 64'(h), 64'd0);
    check("busy start div_zero", 64'(z), 64'd0);
    check("busy start latency", 64'(lat), 64'd33);

    // Cancel mid-ITER with start held: no done, result registers hold
    do_op(MULTU, 32'd6, 32'd7, 0, h, l, z, lat);
    @(negedge clk);
    op = DIVU; rs = 32'd100; rt = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("cancel busy before", 64'(busy), 64'd1);
    cancel = 1'b1; start = 1'b1; op = MULTU; rs = 32'd9; rt = 32'd9;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel done", 64'(done), 64'd0);
    check("cancel hi", 64'(hi), 64'd0);
    check("cancel lo", 64'(lo), 64'd42);
    do_op(DIVU, 32'd100, 32'd7, 0, h, l, z, lat);
    check("after cancel lo", 64'(l), 64'd14);
    check("after cancel hi", 64'(h), 64'd2);
    check("after cancel latency", 64'(lat), 64'd33);

    // Back-to-back: start accepted in the DONE cycle
    do_op(DIVU, 32'h0000_1234, 32'd0, 0, h, l, z, lat);
    check("b2b dz", 64'(z), 64'd1);
    do_op(MULTU, 32'd2, 32'd3, 0, h, l, z, lat);
    check("b2b clears div_zero", 64'(z), 64'd0);
    check("b2b lo", 64'(l), 64'd6);
    check("b2b latency", 64'(lat), 64'd33);

    // Asynchronous reset mid-DIV
    do_op(DIVU, 32'd100, 32'd7, 0, h, l, z, lat);
    @(negedge clk);
    op = DIV; rs = 32'hFFFF_FFF9; rt = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    check("async rst hi", 64'(hi), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    check("async rst alu_control", 64'(alu_control), 64'(ALU_NONE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = muldiv_op_e'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'h8000_0000;
        3: rb = $urandom_range(1, 16);
        default: ;
      endcase
      exp_q.push_back(model(ro, ra, rb));
      do_op(ro, ra, rb, 0, h, l, z, lat);
      exp_v = exp_q.pop_front();
      check($sformatf("rand%0d op%0d hi", i, ro), 64'(h), 64'(exp_v[63:32]));
      check($sformatf("rand%0d op%0d lo", i, ro), 64'(l), 64'(exp_v[31:0]));
      check($sformatf("rand%0d op%0d div_zero", i, ro), 64'(z), 64'(exp_v[64]));
      check($sformatf("rand%0d op%0d latency", i, ro), 64'(lat), 64'(model_lat(ro, rb)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
